image_streamer: RTL and testbench

Double-buffered image source that sits directly upstream of the convolutional windower. The downstream windower requires each image to arrive as an unbroken run of 2^LOG2_IMG_SIZE valid beats of THROUGHPUT samples. This block absorbs bursty, back-pressured input and releases each image only once it is fully buffered, so that guarantee holds. It is the transmitter for the windower's vld/data receiver.

---
 rtl/image_streamer_pkg.sv | 17 +
 rtl/image_streamer_if.sv | 25 ++
 rtl/image_streamer_bank_ram.sv | 29 ++
 rtl/image_streamer.sv | 122 ++++++++++++
 tb/tb_image_streamer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/image_streamer_pkg.sv
// Shared types for the image streamer.
// Contents:
//   rd_state_e - read-side FSM states (ST_IDLE, ST_STREAM, ST_GAP)
//   word_w()   - RAM word width, i.e. all lanes of one beat side by side
package image_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } rd_state_e;

  function automatic int word_w(input int no_ch, input int throughput);
    return no_ch * throughput;
  endfunction

endpackage

// File: rtl/image_streamer_if.sv
// Beat-level signals of the image streamer: the upstream vld/rdy side and
// the downstream vld-only side that feeds the windower.
//   master : the environment (upstream source + windower)
//   slave  : the image_streamer itself
// Data beats are THROUGHPUT lanes of NO_CH bits, and lane k is data[k].
// last_out exists only when IMAGE_STREAMER_LAST_EN is defined.
interface image_streamer_if #(
  parameter int NO_CH      = 2,
  parameter int THROUGHPUT = 1
);
  logic                             vld_in;
  logic                             rdy_in;
  logic [THROUGHPUT-1:0][NO_CH-1:0] data_in;
  logic                             vld_out;
  logic [THROUGHPUT-1:0][NO_CH-1:0] data_out;
`ifdef IMAGE_STREAMER_LAST_EN
  logic                             last_out;

  modport master (output vld_in, data_in, input rdy_in, vld_out, data_out, last_out);
  modport slave  (input vld_in, data_in, output rdy_in, vld_out, data_out, last_out);
`else
  modport master (output vld_in, data_in, input rdy_in, vld_out, data_out);
  modport slave  (input vld_in, data_in, output rdy_in, vld_out, data_out);
`endif
endinterface

// File: rtl/image_streamer_bank_ram.sv
// img_bank_ram: simple dual-port RAM that holds both image banks.
// The address is {bank, addr}. The read port is registered. rdata clears on
// rst, so the streamer's data output reads as zero after a reset.
//   clk, rst            clock, synchronous active-high reset (read register only)
//   we, waddr, wdata    write port
//   re, raddr, rdata    registered read port; rdata holds its value when re is low
module img_bank_ram #(
  parameter int AW = 5,
  parameter int W  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/image_streamer.sv
// image_streamer: double-buffered image source placed in front of the windower.
// It takes bursty, back-pressured beats from upstream and fills one bank at a
// time. A bank is released only when it is full, so every image leaves as
// 2^LOG2_IMG_SIZE contiguous vld_out beats. Consecutive images are separated
// by GAP_CYCLES idle cycles.
//   clk, rst : clock, synchronous active-high reset
//   s        : image_streamer_if.slave (vld_in/rdy_in/data_in in,
//              vld_out/data_out[/last_out] out)
// Optional: when IMAGE_STREAMER_LAST_EN is defined, last_out marks the final
// beat of each image.
module image_streamer
  import image_stream_pkg::*;
#(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int GAP_CYCLES    = 2
) (
  input  logic           clk,
  input  logic           rst,
  image_streamer_if.slave s
);
  localparam int            W         = word_w(NO_CH, THROUGHPUT);
  localparam int            AW        = LOG2_IMG_SIZE;
  localparam int            GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] ADDR_LAST = '1;

  logic          wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    full;
  rd_state_e     state;
  logic [GW-1:0] gap_cnt;
  logic          xfer, issue, issue_last, vld_q;
  logic [W-1:0]  rdata;

  assign s.rdy_in   = !full[wr_bank] && !rst;
  assign xfer       = s.vld_in && s.rdy_in;
  assign issue      = (state == ST_STREAM);
  assign issue_last = issue && (rd_addr == ADDR_LAST);

  // Write side: the bank flips when the address wraps.
  always_ff @(posedge clk)
    if (rst) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (xfer) begin
      wr_addr <= wr_addr + AW'(1);
      if (wr_addr == ADDR_LAST) wr_bank <= ~wr_bank;
    end

  // A set and a clear in the same cycle always hit different banks, so both
  // take effect.
  always_ff @(posedge clk)
    if (rst) full <= '0;
    else begin
      if (xfer && wr_addr == ADDR_LAST) full[wr_bank] <= 1'b1;
      if (issue_last)                   full[rd_bank] <= 1'b0;
    end

  // Read FSM. rd_addr wraps to 0 by itself on the last issue.
  // GAP goes straight to STREAM when the next bank is already full. This way
  // vld_out is low for exactly GAP_CYCLES cycles. Going through IDLE would
  // add one more cycle.
  always_ff @(posedge clk)
    if (rst) begin
      state   <= ST_IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (full[rd_bank]) begin
            state   <= ST_STREAM;
            rd_addr <= '0;
          end
        ST_STREAM: begin
          rd_addr <= rd_addr + AW'(1);
          if (rd_addr == ADDR_LAST) begin
            rd_bank <= ~rd_bank;
            gap_cnt <= '0;
            if (GAP_CYCLES > 0)       state <= ST_GAP;
            else if (!full[~rd_bank]) state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GW'(GAP_CYCLES - 1))
            state <= full[rd_bank] ? ST_STREAM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end

  img_bank_ram #(.AW(AW + 1), .W(W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer),
    .waddr ({wr_bank, wr_addr}),
    .wdata (s.data_in),
    .re    (issue),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rdata)
  );

  // Output flags line up with the registered RAM read.
  always_ff @(posedge clk)
    if (rst) vld_q <= 1'b0;
    else     vld_q <= issue;

  assign s.vld_out  = vld_q;
  assign s.data_out = rdata;

`ifdef IMAGE_STREAMER_LAST_EN
  logic last_q;
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b0;
    else     last_q <= issue_last;
  assign s.last_out = last_q;
`endif

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer with two instances:
//   dut_a : 16-beat images, 1 lane of 4 bits, GAP_CYCLES=2
//   dut_b : 16-beat images, 4 lanes of 4 bits, GAP_CYCLES=0
// Output beats are logged as (cycle, data, last). Every image is checked for
// latency, contiguity, gap length and data order.
module tb_image_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, npass = 0;

  image_streamer_if #(.NO_CH(4), .THROUGHPUT(1)) ifa ();
  image_streamer_if #(.NO_CH(4), .THROUGHPUT(4)) ifb ();

  image_streamer #(.NO_CH(4), .LOG2_IMG_SIZE(4), .THROUGHPUT(1), .GAP_CYCLES(2))
    dut_a (.clk(clk), .rst(rst_a), .s(ifa));
  image_streamer #(.NO_CH(4), .LOG2_IMG_SIZE(4), .THROUGHPUT(4), .GAP_CYCLES(0))
    dut_b (.clk(clk), .rst(rst_b), .s(ifb));

  // output logs
  int          qa_cyc[$], qb_cyc[$];
  logic [15:0] qa_dat[$], qb_dat[$];
  logic        qa_lst[$], qb_lst[$];
  logic [15:0] exp_a[$], exp_b[$];
  int          stall_a = 0;

  always @(negedge clk) begin
    if (ifa.vld_out) begin
      qa_cyc.push_back(cyc);
      qa_dat.push_back(16'(ifa.data_out));
`ifdef IMAGE_STREAMER_LAST_EN
      qa_lst.push_back(ifa.last_out);
`endif
    end
    if (ifb.vld_out) begin
      qb_cyc.push_back(cyc);
      qb_dat.push_back(16'(ifb.data_out));
`ifdef IMAGE_STREAMER_LAST_EN
      qb_lst.push_back(ifb.last_out);
`endif
    end
  end

  always @(posedge clk)
    if (ifa.vld_in && !ifa.rdy_in && !rst_a) stall_a <= stall_a + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // acc = cyc at the negedge just before the transfer edge
  task automatic send_a(input logic [3:0] v, output int acc);
    int g = 0;
    @(negedge clk);
    ifa.vld_in = 1'b1; ifa.data_in = v;
    while (!ifa.rdy_in && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("a_send_timeout", 0, 1);
    acc = cyc;
    exp_a.push_back(16'(v));
    @(posedge clk);
  endtask

  task automatic send_b(input logic [15:0] v, output int acc);
    int g = 0;
    @(negedge clk);
    ifb.vld_in = 1'b1; ifb.data_in = v;
    while (!ifb.rdy_in && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("b_send_timeout", 0, 1);
    acc = cyc;
    exp_b.push_back(v);
    @(posedge clk);
  endtask

  task automatic idle_a(input int n);
    if (n > 0) begin
      @(negedge clk); ifa.vld_in = 1'b0;
      repeat (n - 1) @(negedge clk);
    end
  endtask

  // first beat at cycle f0, images of 16 beats separated by gap idle cycles
  task automatic check_a(input string tag, input int n, input int f0, input int gap);
    chk({tag, "_count"}, qa_cyc.size(), n);
    if (qa_cyc.size() >= n)
      for (int i = 0; i < n; i++) begin
        chk({tag, "_cycle"}, qa_cyc[i], f0 + i + gap * (i / 16));
        chk({tag, "_data"}, qa_dat[i], exp_a[i]);
      end
    qa_cyc.delete(); qa_dat.delete(); qa_lst.delete(); exp_a.delete();
  endtask

  initial begin
    int acc, f0, g;
    int gaps[16] = '{0, 2, 1, 0, 3, 0, 0, 1, 2, 0, 0, 3, 1, 0, 2, 0};
    logic [3:0][3:0] w;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.vld_in = 1'b0; ifa.data_in = '0;
    ifb.vld_in = 1'b0; ifb.data_in = '0;
    repeat (3) @(negedge clk);
    chk("a_rst_vld", ifa.vld_out, 0);
    chk("a_rst_data", ifa.data_out, 0);
    chk("a_rst_rdy", ifa.rdy_in, 0);
    chk("b_rst_vld", ifb.vld_out, 0);
    chk("b_rst_data", ifb.data_out, 0);
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_rdy_after_rst", ifa.rdy_in, 1);

    // 1: single image 0..15, continuous
    for (int i = 0; i < 16; i++) send_a(4'(i), acc);
    idle_a(1);
    repeat (25) @(negedge clk);
`ifdef IMAGE_STREAMER_LAST_EN
    for (int i = 0; i < 16 && i < qa_lst.size(); i++) chk("a1_last", qa_lst[i], i == 15);
`endif
    check_a("a1", 16, acc + 3, 0);

    // 2: bursty fill
    for (int i = 0; i < 16; i++) begin
      send_a(4'(i * 5 + 3), acc);
      idle_a(gaps[i]);
    end
    idle_a(1);
    repeat (25) @(negedge clk);
    check_a("a2", 16, acc + 3, 0);

    // 3: three images back to back; one-cycle stall when both banks fill
    stall_a = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        send_a(4'(i + 5 * k), acc);
        if (k == 0 && i == 15) f0 = acc + 3;
      end
    idle_a(1);
    repeat (60) @(negedge clk);
    chk("a3_stalls", stall_a, 1);
    check_a("a3", 48, f0, 2);

    // 4: reset while beat 7 is on the output
    for (int i = 0; i < 16; i++) send_a(4'(i), acc);
    idle_a(1);
    g = 0;
    while (!(ifa.vld_out && ifa.data_out == 4'd7) && g < 60) begin @(negedge clk); g++; end
    chk("a4_reach_beat7", g < 60, 1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("a4_rst_vld", ifa.vld_out, 0);
    chk("a4_rst_data", ifa.data_out, 0);
    chk("a4_rst_rdy", ifa.rdy_in, 0);
    rst_a = 1'b0;
    #1;
    chk("a4_rdy_after_rst", ifa.rdy_in, 1);
    qa_cyc.delete(); qa_dat.delete(); qa_lst.delete(); exp_a.delete();
    for (int i = 0; i < 16; i++) send_a(4'(15 - i), acc);
    idle_a(1);
    repeat (25) @(negedge clk);
    check_a("a4", 16, acc + 3, 0);

    // 5: GAP_CYCLES=0, 4 lanes; two images give 32 contiguous beats
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_rdy_after_rst", ifb.rdy_in, 1);
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 4; k++) w[k] = 4'(i + 3 * k);
      send_b(w, acc);
      if (i == 15) f0 = acc + 3;
    end
    @(negedge clk); ifb.vld_in = 1'b0;
    repeat (40) @(negedge clk);
    chk("b_count", qb_cyc.size(), 32);
    if (qb_cyc.size() >= 32)
      for (int i = 0; i < 32; i++) begin
        chk("b_cycle", qb_cyc[i], f0 + i);
        chk("b_lanes", qb_dat[i], exp_b[i]);
`ifdef IMAGE_STREAMER_LAST_EN
        chk("b_last", qb_lst[i], (i == 15) || (i == 31));
`endif
      end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
